// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Target end of the execute stage's load/store request. Holds DEPTH x 32-bit
//   words with per-byte write enables and returns the read word (or the merged
//   word after a write) one cycle after accept. When built with
//   DSRAM_WAITSTATE_EN, every access takes 1+WAIT_CYCLES cycles and busy is
//   raised during the wait so the hazard unit can stall.
//
// Optional feature macro: DSRAM_WAITSTATE_EN (wait states; undefined = none)
//
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   req_en      in   access request, held by the initiator until req_accept
//   req_wen     in   [3:0] byte write enables, 4'b0000 = read
//   req_addr    in   [31:0] byte address, word index = [ADDR_W+1:2]
//   req_wdata   in   [31:0] lane-aligned write data
//   req_accept  out  request taken this cycle (combinational)
//   busy        out  access in progress, no accept possible
//   rsp_valid   out  one-cycle response pulse
//   rsp_rdata   out  [31:0] read word or merged word after a write
//   rsp_err     out  with rsp_valid: address out of range
module data_sram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_accept,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

`ifdef DSRAM_WAITSTATE_EN
  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WAIT} state_e;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
  typedef enum logic [1:0] {S_IDLE, S_RESP} state_e;
`endif

  localparam bit PARTIAL_MAP = (DEPTH < (1 << ADDR_W));

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef DSRAM_WAITSTATE_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        wen_q, wen_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
`endif

  logic [ADDR_W-1:0] word_idx;
  logic              idx_oob;
  logic              range_err;

  // Access port: fed either by the live request (zero-wait) or by the
  // registered fields when the wait counter expires.
  logic              acc_fire;
  logic [3:0]        acc_wen;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [31:0]       rd_word;
  logic [31:0]       merged;
  logic              mem_we;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    word_idx  = req_addr[ADDR_W+1:2];
    idx_oob   = PARTIAL_MAP && ({1'b0, word_idx} >= (ADDR_W+1)'(DEPTH));
    range_err = (req_addr[31:ADDR_W+2] != '0) | idx_oob;
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    acc_fire    = 1'b0;
    acc_wen     = req_wen;
    acc_idx     = word_idx;
    acc_wdata   = req_wdata;
    acc_err     = range_err;
`ifdef DSRAM_WAITSTATE_EN
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    req_accept  = req_en & (state_q != S_WAIT);
`else
    req_accept  = req_en;
`endif

    case (state_q)
      S_IDLE, S_RESP: begin
        if (req_en) begin
`ifdef DSRAM_WAITSTATE_EN
          if (WAIT_CYCLES == 0) begin
            acc_fire = 1'b1;
            state_d  = S_RESP;
          end else begin
            wen_d   = req_wen;
            idx_d   = word_idx;
            wdata_d = req_wdata;
            err_d   = range_err;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
          end
`else
          acc_fire = 1'b1;
          state_d  = S_RESP;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef DSRAM_WAITSTATE_EN
      S_WAIT: begin
        if (cnt_q == '0) begin
          acc_fire  = 1'b1;
          acc_wen   = wen_q;
          acc_idx   = idx_q;
          acc_wdata = wdata_q;
          acc_err   = err_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    rd_word = mem[acc_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      merged[8*i +: 8] = acc_wen[i] ? acc_wdata[8*i +: 8] : rd_word[8*i +: 8];
    end

    if (acc_fire) begin
      rsp_rdata_d = acc_err ? '0 : merged;
      rsp_err_d   = acc_err;
    end

    // The array has no reset; gating with resetn keeps a request presented
    // while reset is held from landing in memory.
    mem_we = acc_fire & ~acc_err & (acc_wen != '0) & resetn;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef DSRAM_WAITSTATE_EN
      cnt_q       <= '0;
      wen_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef DSRAM_WAITSTATE_EN
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef DSRAM_WAITSTATE_EN
  assign busy = (state_q == S_WAIT);
`else
  assign busy = 1'b0;
`endif

endmodule
